// File: rtl/nec_tx_if.sv
// rtl/nec_tx_if.sv - frame request and IR line bundle for the NEC transmitter
interface nec_tx_if;
  logic       start;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       busy;
  logic       done;
  logic       ir_out;
  logic       ir_led;

  modport master (
    output start, addr, cmd,
    input  busy, done, ir_out, ir_led
  );

  modport slave (
    input  start, addr, cmd,
    output busy, done, ir_out, ir_led
  );
endinterface

// File: rtl/nec_tx.sv
// rtl/nec_tx.sv - NEC infrared frame transmitter with 38 kHz carrier modulation
module nec_tx #(
  parameter int T_LEAD       = 450000,
  parameter int T_SPACE      = 225000,
  parameter int T_MARK       = 28000,
  parameter int T_ONE        = 84500,
  parameter int T_ZERO       = 28000,
  parameter int CARRIER_HALF = 658
) (
  input  logic     clk,
  input  logic     rst,
  nec_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP
  } state_t;

  // Duration counter holds "cycles remaining minus one" in the current phase.
  localparam logic [19:0] L_LEAD  = 20'(T_LEAD - 1);
  localparam logic [19:0] L_SPACE = 20'(T_SPACE - 1);
  localparam logic [19:0] L_MARK  = 20'(T_MARK - 1);
  localparam logic [19:0] L_ONE   = 20'(T_ONE - 1);
  localparam logic [19:0] L_ZERO  = 20'(T_ZERO - 1);
  localparam logic [15:0] L_CAR   = 16'(CARRIER_HALF - 1);

  state_t      r_state;
  logic [19:0] r_cnt;
  logic [31:0] r_word;
  logic [4:0]  r_bit_idx;
  logic [15:0] r_car_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_ir_out;
  logic        r_ir_led;

  state_t      w_state_nxt;
  logic [19:0] w_cnt_nxt;
  logic [31:0] w_word_nxt;
  logic [4:0]  w_bit_idx_nxt;
  logic [15:0] w_car_cnt_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_ir_out_nxt;
  logic        w_ir_led_nxt;
  logic        w_cnt_zero;
  logic        w_mark_cur;
  logic        w_mark_nxt;

  assign w_cnt_zero = (r_cnt == 20'd0);
  assign w_mark_cur = (r_state == S_LEAD) || (r_state == S_BIT_MARK) || (r_state == S_STOP);
  assign w_mark_nxt = (w_state_nxt == S_LEAD) || (w_state_nxt == S_BIT_MARK) ||
                      (w_state_nxt == S_STOP);

  // State, phase timer, shift word and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 20'd0;
      r_word    <= 32'd0;
      r_bit_idx <= 5'd0;
      r_car_cnt <= 16'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ir_out  <= 1'b1;
      r_ir_led  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_word    <= w_word_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_car_cnt <= w_car_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ir_out  <= w_ir_out_nxt;
      r_ir_led  <= w_ir_led_nxt;
    end
  end

  // Phase sequencing: each phase runs until the timer hits zero, then reloads for the next.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_zero ? r_cnt : (r_cnt - 20'd1);
    w_word_nxt    = r_word;
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = S_LEAD;
          w_cnt_nxt     = L_LEAD;
          w_word_nxt    = {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
          w_bit_idx_nxt = 5'd0;
        end
      end
      S_LEAD: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_SPACE;
          w_cnt_nxt   = L_SPACE;
        end
      end
      S_SPACE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_BIT_MARK;
          w_cnt_nxt   = L_MARK;
        end
      end
      S_BIT_MARK: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_BIT_SPACE;
          w_cnt_nxt   = r_word[0] ? L_ONE : L_ZERO;
        end
      end
      S_BIT_SPACE: begin
        if (w_cnt_zero) begin
          w_word_nxt    = {1'b0, r_word[31:1]};
          w_bit_idx_nxt = r_bit_idx + 5'd1;
          w_cnt_nxt     = L_MARK;
          w_state_nxt   = (r_bit_idx == 5'd31) ? S_STOP : S_BIT_MARK;
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 20'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 20'd0;
      end
    endcase
  end

  // Output values for the coming state; the carrier phase restarts high at every mark start.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
    w_ir_out_nxt  = !w_mark_nxt;
    w_car_cnt_nxt = 16'd0;
    w_ir_led_nxt  = 1'b0;
    if (w_mark_nxt) begin
      if (!w_mark_cur) begin
        w_ir_led_nxt = 1'b1;
      end else if (r_car_cnt == L_CAR) begin
        w_ir_led_nxt = !r_ir_led;
      end else begin
        w_car_cnt_nxt = r_car_cnt + 16'd1;
        w_ir_led_nxt  = r_ir_led;
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.ir_out = r_ir_out;
  assign bus.ir_led = r_ir_led;

endmodule

// File: tb/tb_nec_tx.sv
// tb/tb_nec_tx.sv - randomized self-checking bench for nec_tx against a waveform model
module tb_nec_tx;
  localparam int T_LEAD = 16, T_SPACE = 8, T_MARK = 2, T_ONE = 6, T_ZERO = 2, CARRIER_HALF = 1;
  localparam logic [3:0] IDLE_OUT = 4'b1000;   // {ir_out, ir_led, busy, done}
  localparam logic [3:0] DONE_OUT = 4'b1001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  nec_tx_if bus();

  nec_tx #(
    .T_LEAD(T_LEAD), .T_SPACE(T_SPACE), .T_MARK(T_MARK),
    .T_ONE(T_ONE), .T_ZERO(T_ZERO), .CARRIER_HALF(CARRIER_HALF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_cur = IDLE_OUT;

  logic [31:0] dec_word = 0, last_word = 0;
  int hi_run = 0, busy_len = 0, last_len = 0, done_cnt = 0;

  function automatic void push_mark(int len);
    for (int p = 0; p < len; p++) begin
      logic led;
      led = (((p / CARRIER_HALF) % 2) == 0);
      exp_q.push_back({1'b0, led, 1'b1, 1'b0});
    end
  endfunction

  function automatic void push_space(int len);
    for (int p = 0; p < len; p++) exp_q.push_back(4'b1010);
  endfunction

  function automatic void build_frame(logic [7:0] a, logic [7:0] c);
    logic [31:0] w;
    w = {~c, c, ~a, a};
    push_mark(T_LEAD);
    push_space(T_SPACE);
    for (int i = 0; i < 32; i++) begin
      push_mark(T_MARK);
      push_space(w[i] ? T_ONE : T_ZERO);
    end
    push_mark(T_MARK);
    exp_q.push_back(DONE_OUT);
  endfunction

  // Model: a frame is a precomputed list of per-cycle outputs; a new one starts only when the list is empty.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      exp_cur = IDLE_OUT;
    end else begin
      if (exp_q.size() == 0 && bus.start) build_frame(bus.addr, bus.cmd);
      exp_cur = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_OUT;
    end
  end

  // Per-cycle compare against the model, plus a space-length decoder of the line.
  always @(negedge clk) begin
    checks++;
    if ({bus.ir_out, bus.ir_led, bus.busy, bus.done} !== exp_cur) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t ir/led/busy/done got %b expected %b", $time,
               {bus.ir_out, bus.ir_led, bus.busy, bus.done}, exp_cur);
    end
    if (!rst) begin
      dec_word = 0; hi_run = 0; busy_len = 0;
    end else begin
      if (bus.busy) begin
        busy_len++;
        if (bus.ir_out) hi_run++;
        else begin
          if (hi_run == T_ONE) dec_word = {1'b1, dec_word[31:1]};
          else if (hi_run == T_ZERO) dec_word = {1'b0, dec_word[31:1]};
          hi_run = 0;
        end
      end
      if (bus.done) begin
        last_word = dec_word; last_len = busy_len; done_cnt++;
        dec_word = 0; hi_run = 0; busy_len = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] c);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.addr = a; bus.cmd = c;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 400);
    chk(name, bus.done, 1);
  endtask

  task automatic frame_result(input string name, input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    chk({name, "_word"}, last_word, {~c, c, ~a, a});
    chk({name, "_len"}, last_len, 218);
  endtask

  initial begin
    logic [7:0] a, c, a2, c2;
    logic [31:0] fw[3];
    int d0;
    bus.start = 1'b0; bus.addr = 8'h00; bus.cmd = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_ir_out", bus.ir_out, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_ir_led", bus.ir_led, 0);
    @(posedge clk); #2 rst = 1'b1;

    // Scenario 1 and 6: all-zero bytes, literal timing and carrier pins
    pulse_start(8'h00, 8'h00);
    @(negedge clk);
    chk("s1_c1_ir_out", bus.ir_out, 0);
    chk("s1_c1_busy", bus.busy, 1);
    chk("s6_c1_led", bus.ir_led, 1);
    @(negedge clk); chk("s6_c2_led", bus.ir_led, 0);
    @(negedge clk); chk("s6_c3_led", bus.ir_led, 1);
    repeat (13) @(negedge clk); chk("s1_c16_ir_out", bus.ir_out, 0);
    @(negedge clk);
    chk("s1_c17_ir_out", bus.ir_out, 1);
    chk("s6_c17_led", bus.ir_led, 0);
    repeat (7) @(negedge clk); chk("s1_c24_ir_out", bus.ir_out, 1);
    repeat (194) @(negedge clk);
    chk("s1_c218_busy", bus.busy, 1);
    chk("s1_c218_done", bus.done, 0);
    @(negedge clk);
    chk("s1_c219_done", bus.done, 1);
    chk("s1_c219_busy", bus.busy, 0);
    chk("s1_c219_ir_out", bus.ir_out, 1);
    @(negedge clk);
    chk("s1_c220_done", bus.done, 0);
    chk("s1_word", last_word, 32'hFF00FF00);
    chk("s1_len", last_len, 218);

    // Scenario 2: known bytes decode to a fixed word
    pulse_start(8'h5A, 8'hC3);
    wait_done("s2_done");
    @(negedge clk);
    chk("s2_word", last_word, 32'h3CC3A55A);
    chk("s2_len", last_len, 218);

    // Scenario 3: start mid-frame with other data is ignored
    a = 8'($urandom); c = 8'($urandom); a2 = ~a; c2 = c ^ 8'h5A;
    d0 = done_cnt;
    pulse_start(a, c);
    repeat (48) @(negedge clk);
    pulse_start(a2, c2);
    wait_done("s3_done");
    frame_result("s3", a, c);
    repeat (300) @(negedge clk);
    chk("s3_single_done", done_cnt, d0 + 1);

    // Scenario 4: start held high gives back-to-back frames
    for (int f = 0; f < 3; f++) fw[f] = $urandom;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.addr = fw[0][7:0]; bus.cmd = fw[0][15:8];
    for (int f = 0; f < 3; f++) begin
      wait_done("s4_done");
      if (f == 2) bus.start = 1'b0;
      else begin
        bus.addr = fw[f + 1][7:0]; bus.cmd = fw[f + 1][15:8];
      end
      @(negedge clk);
      chk("s4_word", last_word, {~fw[f][15:8], fw[f][15:8], ~fw[f][7:0], fw[f][7:0]});
      chk("s4_next_busy", bus.busy, (f < 2) ? 1 : 0);
      chk("s4_next_ir_out", bus.ir_out, (f < 2) ? 0 : 1);
    end

    // Scenario 5: asynchronous reset mid-frame aborts with no done
    d0 = done_cnt;
    pulse_start(8'($urandom), 8'($urandom));
    repeat (100) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("s5_async_ir_out", bus.ir_out, 1);
    chk("s5_async_busy", bus.busy, 0);
    chk("s5_async_led", bus.ir_led, 0);
    chk("s5_async_done", bus.done, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    chk("s5_no_done", done_cnt, d0);
    a = 8'($urandom); c = 8'($urandom);
    pulse_start(a, c);
    wait_done("s5_done");
    frame_result("s5", a, c);
    chk("s5_one_done", done_cnt, d0 + 1);

    // Randomized frames with idle gaps and stray mid-frame starts
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      a = 8'($urandom); c = 8'($urandom);
      pulse_start(a, c);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 190)) @(negedge clk);
        pulse_start(8'($urandom), 8'($urandom));
      end
      wait_done("rnd_done");
      frame_result("rnd", a, c);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nec_tx.md
NEC_TX -- requirements
Module: nec_tx

Interface
REQ-001 Parameter T_LEAD, default 450000, leader mark length in clk cycles (9 ms at 50 MHz).
REQ-002 Parameter T_SPACE, default 225000, leader space length in clk cycles (4.5 ms).
REQ-003 Parameter T_MARK, default 28000, bit/stop mark length in clk cycles (560 us).
REQ-004 Parameter T_ONE, default 84500, logic-1 space length in clk cycles (1.69 ms).
REQ-005 Parameter T_ZERO, default 28000, logic-0 space length in clk cycles (560 us).
REQ-006 Parameter CARRIER_HALF, default 658, carrier half-period in clk cycles (~38 kHz).
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  frame request, sampled only in IDLE.
REQ-010 addr  input  8  address byte, latched on accepted start.
REQ-011 cmd  input  8  command byte, latched on accepted start.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 done  output  1  one-cycle pulse at frame completion.
REQ-014 ir_out  output  1  demodulated-polarity line: idle high, mark = low.
REQ-015 ir_led  output  1  carrier-modulated LED drive: carrier during mark, 0 otherwise.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be IDLE, LEAD, SPACE, BIT_MARK, BIT_SPACE, STOP; one-hot or binary is implementer's choice.
REQ-018 In IDLE with start=1 at edge N, the block SHALL latch frame word {~cmd, cmd, ~addr, addr} (addr in bits 7:0), clear the bit counter, and enter LEAD; busy=1 and ir_out=0 from cycle N+1.
REQ-019 start while busy=1 SHALL be ignored; addr/cmd changes after acceptance SHALL not affect the frame.
REQ-020 LEAD SHALL hold ir_out=0 for exactly T_LEAD cycles, then SPACE.
REQ-021 SPACE SHALL hold ir_out=1 for exactly T_SPACE cycles, then BIT_MARK.
REQ-022 BIT_MARK SHALL hold ir_out=0 for exactly T_MARK cycles, then BIT_SPACE.
REQ-023 BIT_SPACE SHALL hold ir_out=1 for T_ONE cycles if current bit=1, else T_ZERO cycles.
REQ-024 Bits SHALL be sent LSB first (word bit 0 first), 32 bits total; after bit 31's space, enter STOP, else BIT_MARK with next bit.
REQ-025 STOP SHALL hold ir_out=0 for exactly T_MARK cycles, then IDLE.
REQ-026 On the cycle ir_out returns high after STOP, done=1 for one cycle and busy=0; a start on that same cycle SHALL be accepted.
REQ-027 Duration counter SHALL be 20 bits, reloaded at every state change, no wrap within any phase.
REQ-028 Carrier counter SHALL restart at every mark start; ir_led=1 for the first CARRIER_HALF cycles, 0 for the next CARRIER_HALF, repeating; ir_led=0 whenever ir_out=1.
REQ-029 Frame length SHALL be independent of addr/cmd (always 16 ones, 16 zeros).

Reset
REQ-030 rst=0 SHALL immediately force IDLE, busy=0, done=0, ir_out=1, ir_led=0, counters and shift word cleared.
REQ-031 Reset mid-frame SHALL abort without a done pulse; first start after release SHALL begin a full new frame.

Verification
REQ-032 Use T_LEAD=16, T_SPACE=8, T_MARK=2, T_ONE=6, T_ZERO=2, CARRIER_HALF=1 unless stated.
REQ-033 Scenario 1: start at N, addr=0x00, cmd=0x00 -> ir_out low N+1..N+16, high N+17..N+24, done=1 at N+219 only, busy high N+1..N+218.
REQ-034 Scenario 2: addr=0x5A, cmd=0xC3, bench decodes spaces (6=1, 2=0) -> 32-bit word 0x3CC3A55A, frame again 218 cycles.
REQ-035 Scenario 3: start pulsed at N+50 mid-frame with different addr/cmd -> ignored, decoded word unchanged, single done.
REQ-036 Scenario 4: start held high continuously -> back-to-back frames, new LEAD begins at cycle after done, no idle gap.
REQ-037 Scenario 5: rst=0 at N+100 -> ir_out=1, busy=0, ir_led=0 asynchronously; no done; next start yields full correct frame.
REQ-038 Scenario 6: during LEAD, ir_led toggles every cycle starting 1 at N+1; ir_led=0 throughout all spaces.
